// File: rtl/mem_access.sv
// mem_access: memory-access stage of the unpipelined MIPS core.
// Takes the effective address and store data from execute, runs one access on
// a req/ack data-memory port, and returns the extended load result with a
// one-cycle done pulse. A misaligned or illegal access faults without touching
// the bus. A request with no ack within MAX_WAIT cycles times out.
//
// Ports:
//   i_clk, i_rst_n         clock (rising edge), synchronous active-low reset
//   i_valid                instruction present from the execute stage
//   i_memRead, i_memWrite  load / store instruction
//   i_size                 00 byte, 01 half, 10 word, 11 illegal
//   i_unsigned             zero-extend the load result (lbu/lhu)
//   i_ALUres               effective byte address
//   i_op2                  store data (rt)
//   o_stall                hold PC/upstream (combinational)
//   o_done                 one-cycle completion pulse
//   o_rdata                extended load result, valid with o_done
//   o_fault                misaligned/illegal access, valid with o_done
//   o_timeout              no ack within MAX_WAIT, valid with o_done
//   o_dm_req/we/addr/be/wdata  data-memory request port
//   i_dm_ack, i_dm_rdata   memory ack and read word (same cycle for reads)
module mem_access #(
    parameter int unsigned MAX_WAIT = 255
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_valid,
    input  logic        i_memRead,
    input  logic        i_memWrite,
    input  logic [1:0]  i_size,
    input  logic        i_unsigned,
    input  logic [31:0] i_ALUres,
    input  logic [31:0] i_op2,
    output logic        o_stall,
    output logic        o_done,
    output logic [31:0] o_rdata,
    output logic        o_fault,
    output logic        o_timeout,
    output logic        o_dm_req,
    output logic        o_dm_we,
    output logic [31:0] o_dm_addr,
    output logic [3:0]  o_dm_be,
    output logic [31:0] o_dm_wdata,
    input  logic        i_dm_ack,
    input  logic [31:0] i_dm_rdata
);

    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_WAIT - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    // Registered state
    logic [1:0]       state_q,   state_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic             req_q,     req_d;
    logic             we_q,      we_d;
    logic [31:0]      addr_q,    addr_d;
    logic [3:0]       be_q,      be_d;
    logic [31:0]      wdata_q,   wdata_d;
    logic [1:0]       lane_q,    lane_d;
    logic [1:0]       size_q,    size_d;
    logic             zext_q,    zext_d;
    logic             done_q,    done_d;
    logic [31:0]      rdata_q,   rdata_d;
    logic             fault_q,   fault_d;
    logic             timeout_q, timeout_d;

    // Decode of the instruction currently offered by execute
    logic        start_c;
    logic        fault_c;
    logic [3:0]  st_be_c;
    logic [31:0] st_wdata_c;

    // Select and extend the addressed byte/half of a read word.
    function automatic logic [31:0] load_extract(
        input logic [31:0] word,
        input logic [1:0]  lane,
        input logic [1:0]  size,
        input logic        zext
    );
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = lane[1] ? word[31:16] : word[15:0];
        case (size)
            SZ_BYTE: r = zext ? {24'd0, b} : {{24{b[7]}}, b};
            SZ_HALF: r = zext ? {16'd0, h} : {{16{h[15]}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

    assign start_c = i_valid & (i_memRead | i_memWrite);

    // Simultaneous read+write, the reserved size, or a misaligned half/word.
    assign fault_c = (i_memRead & i_memWrite)
                   | (i_size == SZ_ILL)
                   | ((i_size == SZ_HALF) & i_ALUres[0])
                   | ((i_size == SZ_WORD) & (i_ALUres[1:0] != 2'b00));

    // Store lane steering: data replicated across lanes, enables pick the target.
    always_comb begin
        st_be_c    = 4'b1111;
        st_wdata_c = 32'd0;
        if (i_memWrite) begin
            case (i_size)
                SZ_BYTE: begin
                    st_be_c    = 4'b0001 << i_ALUres[1:0];
                    st_wdata_c = {4{i_op2[7:0]}};
                end
                SZ_HALF: begin
                    st_be_c    = i_ALUres[1] ? 4'b1100 : 4'b0011;
                    st_wdata_c = {2{i_op2[15:0]}};
                end
                default: begin
                    st_be_c    = 4'b1111;
                    st_wdata_c = i_op2;
                end
            endcase
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        req_d     = req_q;
        we_d      = we_q;
        addr_d    = addr_q;
        be_d      = be_q;
        wdata_d   = wdata_q;
        lane_d    = lane_q;
        size_d    = size_q;
        zext_d    = zext_q;
        done_d    = 1'b0;
        rdata_d   = 32'd0;
        fault_d   = 1'b0;
        timeout_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_c) begin
                    if (fault_c) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        fault_d = 1'b1;
                    end else begin
                        state_d = REQ;
                        cnt_d   = '0;
                        req_d   = 1'b1;
                        we_d    = i_memWrite;
                        addr_d  = {i_ALUres[31:2], 2'b00};
                        be_d    = st_be_c;
                        wdata_d = st_wdata_c;
                        lane_d  = i_ALUres[1:0];
                        size_d  = i_size;
                        zext_d  = i_unsigned;
                    end
                end
            end

            REQ: begin
                // Ack is checked first so it wins over the final timeout cycle.
                if (i_dm_ack) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    rdata_d = we_q ? 32'd0
                                   : load_extract(i_dm_rdata, lane_q, size_q, zext_q);
                end else if (cnt_q == LAST_CNT) begin
                    state_d   = DONE;
                    done_d    = 1'b1;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                if (state_d == DONE) begin
                    cnt_d   = '0;
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    addr_d  = 32'd0;
                    be_d    = 4'd0;
                    wdata_d = 32'd0;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                req_d   = 1'b0;
                we_d    = 1'b0;
                addr_d  = 32'd0;
                be_d    = 4'd0;
                wdata_d = 32'd0;
            end
        endcase
    end

    // State register; reset also aborts an in-flight request.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= 32'd0;
            be_q      <= 4'd0;
            wdata_q   <= 32'd0;
            lane_q    <= 2'd0;
            size_q    <= 2'd0;
            zext_q    <= 1'b0;
            done_q    <= 1'b0;
            rdata_q   <= 32'd0;
            fault_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            req_q     <= req_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            be_q      <= be_d;
            wdata_q   <= wdata_d;
            lane_q    <= lane_d;
            size_q    <= size_d;
            zext_q    <= zext_d;
            done_q    <= done_d;
            rdata_q   <= rdata_d;
            fault_q   <= fault_d;
            timeout_q <= timeout_d;
        end
    end

    // Stall must hold upstream in the very cycle a memory op is offered.
    assign o_stall    = ((state_q == IDLE) && start_c) || (state_q == REQ);
    assign o_done     = done_q;
    assign o_rdata    = rdata_q;
    assign o_fault    = fault_q;
    assign o_timeout  = timeout_q;
    assign o_dm_req   = req_q;
    assign o_dm_we    = we_q;
    assign o_dm_addr  = addr_q;
    assign o_dm_be    = be_q;
    assign o_dm_wdata = wdata_q;

endmodule

// File: tb/tb_mem_access.sv
module tb_mem_access;

    localparam int unsigned MAX_WAIT = 4;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_valid;
    logic        i_memRead;
    logic        i_memWrite;
    logic [1:0]  i_size;
    logic        i_unsigned;
    logic [31:0] i_ALUres;
    logic [31:0] i_op2;
    logic        o_stall;
    logic        o_done;
    logic [31:0] o_rdata;
    logic        o_fault;
    logic        o_timeout;
    logic        o_dm_req;
    logic        o_dm_we;
    logic [31:0] o_dm_addr;
    logic [3:0]  o_dm_be;
    logic [31:0] o_dm_wdata;
    logic        i_dm_ack;
    logic [31:0] i_dm_rdata;

    mem_access #(.MAX_WAIT(MAX_WAIT)) dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_valid    (i_valid),
        .i_memRead  (i_memRead),
        .i_memWrite (i_memWrite),
        .i_size     (i_size),
        .i_unsigned (i_unsigned),
        .i_ALUres   (i_ALUres),
        .i_op2      (i_op2),
        .o_stall    (o_stall),
        .o_done     (o_done),
        .o_rdata    (o_rdata),
        .o_fault    (o_fault),
        .o_timeout  (o_timeout),
        .o_dm_req   (o_dm_req),
        .o_dm_we    (o_dm_we),
        .o_dm_addr  (o_dm_addr),
        .o_dm_be    (o_dm_be),
        .o_dm_wdata (o_dm_wdata),
        .i_dm_ack   (i_dm_ack),
        .i_dm_rdata (i_dm_rdata)
    );

    always #5 i_clk = ~i_clk;

    typedef struct packed {
        logic [31:0] rdata;
        logic        fault;
        logic        timeout;
    } exp_done_t;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } exp_bus_t;

    exp_done_t done_q[$];
    exp_bus_t  bus_q[$];

    int   n_checks = 0;
    int   n_pass   = 0;
    logic mon_en   = 1'b0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endfunction

    // Monitor: compares completions and bus requests against the queued expectations.
    initial begin : monitor
        exp_done_t ed;
        exp_bus_t  cur;
        logic      prev_req;
        prev_req = 1'b0;
        cur      = '0;
        wait (mon_en);
        forever begin
            @(negedge i_clk);
            if (o_done) begin
                if (done_q.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    ed = done_q.pop_front();
                    chk("done_rdata",   o_rdata,          ed.rdata);
                    chk("done_fault",   32'(o_fault),     32'(ed.fault));
                    chk("done_timeout", 32'(o_timeout),   32'(ed.timeout));
                end
            end else begin
                chk("idle_result", {o_rdata[31:2], o_fault, o_timeout}, 32'd0);
            end
            if (o_dm_req) begin
                if (!prev_req) begin
                    if (bus_q.size() == 0) chk("unexpected_req", 32'd1, 32'd0);
                    else cur = bus_q.pop_front();
                end
                chk("bus_addr",  o_dm_addr,      cur.addr);
                chk("bus_we",    32'(o_dm_we),   32'(cur.we));
                chk("bus_be",    32'(o_dm_be),   32'(cur.be));
                chk("bus_wdata", o_dm_wdata,     cur.wdata);
            end
            prev_req = o_dm_req;
        end
    end

    // Issue one access; ack_after = REQ cycles to wait before ack (-1 = never).
    task automatic run_op(
        input string       name,
        input logic        rd,
        input logic        wr,
        input logic [1:0]  sz,
        input logic        uns,
        input logic [31:0] addr,
        input logic [31:0] op2,
        input logic [31:0] mem_word,
        input int          ack_after,
        input logic [31:0] exp_rdata,
        input logic        exp_fault,
        input logic        exp_timeout,
        input logic [3:0]  exp_be,
        input logic [31:0] exp_wdata
    );
        exp_done_t ed;
        exp_bus_t  eb;
        int stalls, reqs, cyc, exp_reqs;
        logic seen;
        i_valid    = 1'b1;
        i_memRead  = rd;
        i_memWrite = wr;
        i_size     = sz;
        i_unsigned = uns;
        i_ALUres   = addr;
        i_op2      = op2;
        i_dm_rdata = mem_word;
        i_dm_ack   = 1'b0;
        ed.rdata   = exp_rdata;
        ed.fault   = exp_fault;
        ed.timeout = exp_timeout;
        done_q.push_back(ed);
        if (!exp_fault) begin
            eb.addr  = {addr[31:2], 2'b00};
            eb.we    = wr;
            eb.be    = exp_be;
            eb.wdata = exp_wdata;
            bus_q.push_back(eb);
        end
        if (exp_fault) exp_reqs = 0;
        else if (ack_after < 0 || ack_after >= int'(MAX_WAIT)) exp_reqs = int'(MAX_WAIT);
        else exp_reqs = ack_after + 1;
        stalls = 0; reqs = 0; cyc = 0; seen = 1'b0;
        while (!seen && cyc < 20) begin
            @(negedge i_clk);
            cyc++;
            if (o_stall) stalls++;
            if (o_dm_req) begin
                reqs++;
                if (ack_after >= 0 && reqs == ack_after + 1) i_dm_ack = 1'b1;
            end
            seen = o_done;
            @(posedge i_clk); #1;
            i_dm_ack = 1'b0;
            if (cyc == 1) begin
                // Upstream inputs change while stalled; the access must not notice.
                i_ALUres   = ~addr;
                i_op2      = ~op2;
                i_size     = ~sz;
                i_unsigned = ~uns;
            end
        end
        chk({name, "_completed"},  32'(seen),   32'd1);
        chk({name, "_stall_cyc"},  32'(stalls), 32'(exp_reqs + 1));
        chk({name, "_req_cyc"},    32'(reqs),   32'(exp_reqs));
        chk({name, "_done_cycle"}, 32'(cyc),    32'(exp_reqs + 2));
        i_valid    = 1'b0;
        i_memRead  = 1'b0;
        i_memWrite = 1'b0;
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        exp_bus_t eb;
        i_rst_n    = 1'b0;
        i_valid    = 1'b0;
        i_memRead  = 1'b0;
        i_memWrite = 1'b0;
        i_size     = 2'b00;
        i_unsigned = 1'b0;
        i_ALUres   = 32'd0;
        i_op2      = 32'd0;
        i_dm_ack   = 1'b0;
        i_dm_rdata = 32'd0;
        repeat (2) @(posedge i_clk);
        #1;
        chk("rst_stall", 32'(o_stall),  32'd0);
        chk("rst_done",  32'(o_done),   32'd0);
        chk("rst_rdata", o_rdata,       32'd0);
        chk("rst_flags", {30'd0, o_fault, o_timeout}, 32'd0);
        chk("rst_req",   32'(o_dm_req), 32'd0);
        chk("rst_bus",   o_dm_addr | o_dm_wdata | 32'(o_dm_be) | 32'(o_dm_we), 32'd0);
        i_rst_n = 1'b1;
        mon_en  = 1'b1;

        // Non-memory instruction with stray ack: no stall, no request, no done.
        i_valid  = 1'b1;
        i_ALUres = 32'h0000_0100;
        i_dm_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge i_clk);
            chk("nonmem_stall", 32'(o_stall),  32'd0);
            chk("nonmem_req",   32'(o_dm_req), 32'd0);
            @(posedge i_clk); #1;
        end
        i_valid  = 1'b0;
        i_dm_ack = 1'b0;

        //      name    rd    wr    size   uns   addr          op2           mem word      ack  rdata         flt   tmo   be       wdata
        run_op("sw",    1'b0, 1'b1, 2'b10, 1'b0, 32'h0000_0100, 32'hDEAD_BEEF, 32'h1111_1111, 0, 32'h0000_0000, 1'b0, 1'b0, 4'b1111, 32'hDEAD_BEEF);
        run_op("lb3",   1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_0103, 32'hFFFF_FFFF, 32'h80FF_1234, 0, 32'hFFFF_FF80, 1'b0, 1'b0, 4'b1111, 32'h0000_0000);
        run_op("lbu3",  1'b1, 1'b0, 2'b00, 1'b1, 32'h0000_0103, 32'hFFFF_FFFF, 32'h80FF_1234, 0, 32'h0000_0080, 1'b0, 1'b0, 4'b1111, 32'h0000_0000);
        run_op("lb0",   1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_0100, 32'hFFFF_FFFF, 32'h80FF_1234, 1, 32'h0000_0034, 1'b0, 1'b0, 4'b1111, 32'h0000_0000);
        run_op("lh2",   1'b1, 1'b0, 2'b01, 1'b0, 32'h0000_0102, 32'h0000_0000, 32'h80FF_1234, 0, 32'hFFFF_80FF, 1'b0, 1'b0, 4'b1111, 32'h0000_0000);
        run_op("lhu2",  1'b1, 1'b0, 2'b01, 1'b1, 32'h0000_0102, 32'h0000_0000, 32'h80FF_1234, 2, 32'h0000_80FF, 1'b0, 1'b0, 4'b1111, 32'h0000_0000);
        run_op("lh0",   1'b1, 1'b0, 2'b01, 1'b0, 32'h0000_0100, 32'h0000_0000, 32'h80FF_9234, 0, 32'hFFFF_9234, 1'b0, 1'b0, 4'b1111, 32'h0000_0000);
        run_op("sh2",   1'b0, 1'b1, 2'b01, 1'b0, 32'h0000_0102, 32'h0000_ABCD, 32'h0000_0000, 0, 32'h0000_0000, 1'b0, 1'b0, 4'b1100, 32'hABCD_ABCD);
        run_op("sh0",   1'b0, 1'b1, 2'b01, 1'b0, 32'h0000_0100, 32'h1234_BEEF, 32'h0000_0000, 0, 32'h0000_0000, 1'b0, 1'b0, 4'b0011, 32'hBEEF_BEEF);
        run_op("sb1",   1'b0, 1'b1, 2'b00, 1'b0, 32'h0000_0101, 32'h0000_005A, 32'h0000_0000, 0, 32'h0000_0000, 1'b0, 1'b0, 4'b0010, 32'h5A5A_5A5A);
        run_op("sb3",   1'b0, 1'b1, 2'b00, 1'b0, 32'h0000_0103, 32'h0000_00A7, 32'h0000_0000, 1, 32'h0000_0000, 1'b0, 1'b0, 4'b1000, 32'hA7A7_A7A7);
        run_op("lwmis", 1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0102, 32'h0000_0000, 32'h0000_0000, 0, 32'h0000_0000, 1'b1, 1'b0, 4'b0000, 32'h0000_0000);
        run_op("szill", 1'b1, 1'b0, 2'b11, 1'b0, 32'h0000_0100, 32'h0000_0000, 32'h0000_0000, 0, 32'h0000_0000, 1'b1, 1'b0, 4'b0000, 32'h0000_0000);
        run_op("rdwr",  1'b1, 1'b1, 2'b10, 1'b0, 32'h0000_0100, 32'h0000_0000, 32'h0000_0000, 0, 32'h0000_0000, 1'b1, 1'b0, 4'b0000, 32'h0000_0000);
        run_op("shmis", 1'b0, 1'b1, 2'b01, 1'b0, 32'h0000_0101, 32'h0000_1234, 32'h0000_0000, 0, 32'h0000_0000, 1'b1, 1'b0, 4'b0000, 32'h0000_0000);
        run_op("lwto",  1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0200, 32'h5555_5555, 32'h7777_7777,-1, 32'h0000_0000, 1'b0, 1'b1, 4'b1111, 32'h0000_0000);
        run_op("lwack4",1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0200, 32'h5555_5555, 32'h1234_5678, 3, 32'h1234_5678, 1'b0, 1'b0, 4'b1111, 32'h0000_0000);
        run_op("lwuns", 1'b1, 1'b0, 2'b10, 1'b1, 32'h0000_0204, 32'h0000_0000, 32'hCAFE_F00D, 1, 32'hCAFE_F00D, 1'b0, 1'b0, 4'b1111, 32'h0000_0000);

        // Reset during the second REQ cycle aborts the access with no done.
        i_valid    = 1'b1;
        i_memRead  = 1'b1;
        i_memWrite = 1'b0;
        i_size     = 2'b10;
        i_unsigned = 1'b0;
        i_ALUres   = 32'h0000_0300;
        i_op2      = 32'hFFFF_FFFF;
        i_dm_rdata = 32'h9999_9999;
        eb.addr  = 32'h0000_0300;
        eb.we    = 1'b0;
        eb.be    = 4'b1111;
        eb.wdata = 32'h0000_0000;
        bus_q.push_back(eb);
        @(posedge i_clk); #1;
        @(posedge i_clk); #1;
        @(negedge i_clk);
        chk("abort_req_before", 32'(o_dm_req), 32'd1);
        i_rst_n   = 1'b0;
        i_valid   = 1'b0;
        i_memRead = 1'b0;
        @(posedge i_clk); #1;
        i_rst_n = 1'b1;
        @(negedge i_clk);
        chk("abort_req_after",   32'(o_dm_req), 32'd0);
        chk("abort_stall_after", 32'(o_stall),  32'd0);
        chk("abort_no_done",     32'(o_done),   32'd0);
        @(posedge i_clk); #1;
        i_dm_ack = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge i_clk);
            chk("late_ack_req",  32'(o_dm_req), 32'd0);
            chk("late_ack_done", 32'(o_done),   32'd0);
            @(posedge i_clk); #1;
        end
        i_dm_ack = 1'b0;

        run_op("lwpost",1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0104, 32'h0000_0000, 32'h0BAD_F00D, 0, 32'h0BAD_F00D, 1'b0, 1'b0, 4'b1111, 32'h0000_0000);

        repeat (3) @(posedge i_clk);
        #1;
        chk("done_queue_empty", 32'(done_q.size()), 32'd0);
        chk("bus_queue_empty",  32'(bus_q.size()),  32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
